// File: rtl/calc_req_arbiter_if.sv
// Requester, calculator and response signals shared between the arbiter and its environment.
// master: requesters plus calculator; slave: the arbiter.
interface calc_req_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [1:0]  req0_func;
  logic [1:0]  req1_func;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic [1:0]  calc_func_in;
  logic [7:0]  calc_A_in;
  logic [7:0]  calc_B_in;
  logic [15:0] calc_out;
  logic        rsp_valid;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_dz;

  modport master (
    output req0_valid, req1_valid, req0_func, req1_func,
           req0_a, req0_b, req1_a, req1_b, calc_out,
    input  req0_ready, req1_ready, calc_func_in, calc_A_in, calc_B_in,
           rsp_valid, rsp_id, rsp_data, rsp_dz
  );

  modport slave (
    input  req0_valid, req1_valid, req0_func, req1_func,
           req0_a, req0_b, req1_a, req1_b, calc_out,
    output req0_ready, req1_ready, calc_func_in, calc_A_in, calc_B_in,
           rsp_valid, rsp_id, rsp_data, rsp_dz
  );
endinterface

// File: rtl/calc_req_arbiter.sv
// Round-robin arbiter sharing one fixed-latency calculator between two requesters,
// with a tag pipe that routes each result back with its requester id and div-by-zero flag.
module calc_req_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  calc_req_arbiter_if.slave bus
);

  typedef enum logic {
    LAST_REQ0 = 1'b0,
    LAST_REQ1 = 1'b1
  } last_t;

  typedef struct packed {
    logic valid;
    logic id;
    logic dz;
  } tag_t;

  last_t      last_q;
  tag_t       tag_q [0:LATENCY];
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic [1:0] sel_func;
  logic [7:0] sel_a;
  logic [7:0] sel_b;

  // req0 wins unless req1 is also valid and req0 was granted last; gated by rst_n so
  // ready stays low throughout reset.
  always_comb begin
    grant0   = rst_n && bus.req0_valid && (!bus.req1_valid || last_q == LAST_REQ1);
    grant1   = rst_n && bus.req1_valid && !grant0;
    accept   = grant0 || grant1;
    sel_func = grant1 ? bus.req1_func : bus.req0_func;
    sel_a    = grant1 ? bus.req1_a    : bus.req0_a;
    sel_b    = grant1 ? bus.req1_b    : bus.req0_b;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q           <= LAST_REQ1;
      bus.calc_func_in <= '0;
      bus.calc_A_in    <= '0;
      bus.calc_B_in    <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_id       <= 1'b0;
      bus.rsp_data     <= '0;
      bus.rsp_dz       <= 1'b0;
      for (int unsigned i = 0; i <= LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        last_q           <= grant1 ? LAST_REQ1 : LAST_REQ0;
        bus.calc_func_in <= sel_func;
        bus.calc_A_in    <= sel_a;
        bus.calc_B_in    <= sel_b;
      end else begin
        bus.calc_func_in <= '0;
        bus.calc_A_in    <= '0;
        bus.calc_B_in    <= '0;
      end

      tag_q[0].valid <= accept;
      tag_q[0].id    <= grant1;
      tag_q[0].dz    <= accept && (sel_func == 2'b11) && (sel_b == '0);
      for (int unsigned i = 1; i <= LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end

      // Result fields only move when a tag leaves the pipe, so they hold between responses.
      bus.rsp_valid <= tag_q[LATENCY].valid;
      if (tag_q[LATENCY].valid) begin
        bus.rsp_id   <= tag_q[LATENCY].id;
        bus.rsp_data <= bus.calc_out;
        bus.rsp_dz   <= tag_q[LATENCY].dz;
      end
    end
  end

endmodule
